riscv_str_unit: RTL and testbench

RISCV_STR_UNIT -- requirements
Module: riscv_str_unit

---
 rtl/riscv_str_unit_if.sv | 36 +++
 rtl/riscv_str_unit.sv | 149 ++++++++++++++
 tb/tb_riscv_str_unit.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_str_unit_if.sv
// Request/response bundle between the execute pipeline and the string unit.
// master is the pipeline side; slave is the unit side.
interface riscv_str_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  enable_i;
  logic [1:0]            operator_i;
  logic [DATA_WIDTH-1:0] operand_i;
  logic                  flush_i;
  logic                  ex_ready_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  valid_o;
  logic                  ready_o;

  modport master (
    output enable_i,
    output operator_i,
    output operand_i,
    output flush_i,
    output ex_ready_i,
    input  result_o,
    input  valid_o,
    input  ready_o
  );

  modport slave (
    input  enable_i,
    input  operator_i,
    input  operand_i,
    input  flush_i,
    input  ex_ready_i,
    output result_o,
    output valid_o,
    output ready_o
  );
endinterface

// File: rtl/riscv_str_unit.sv
// Multi-cycle byte-wise ASCII string transform (upper/lower/leet/rot13).
// Processes LANES_PER_CYCLE bytes per BUSY cycle and holds the result until accepted.
module riscv_str_unit #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned LANES_PER_CYCLE = 1
) (
  input logic            clk,
  input logic            rst_n,
  riscv_str_unit_if.slave str_if
);

  localparam int unsigned NumLanes = DATA_WIDTH / 8;
  localparam int unsigned NumSteps = NumLanes / LANES_PER_CYCLE;
  localparam int unsigned CntW     = (NumSteps > 1) ? $clog2(NumSteps) : 1;

  if ((DATA_WIDTH < 8) || (DATA_WIDTH % 8 != 0)) begin : g_bad_width
    $error("DATA_WIDTH must be a non-zero multiple of 8");
  end
  if ((LANES_PER_CYCLE == 0) || (NumLanes % LANES_PER_CYCLE != 0)) begin : g_bad_lanes
    $error("LANES_PER_CYCLE must evenly divide DATA_WIDTH/8");
  end

  typedef enum logic [1:0] {
    OpUpper = 2'd0,
    OpLower = 2'd1,
    OpLeet  = 2'd2,
    OpRot13 = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  function automatic logic [7:0] xform_byte(op_e op, logic [7:0] b);
    logic       is_up;
    logic       is_lo;
    logic [7:0] folded;
    logic [7:0] r;
    is_up  = (b >= 8'h41) && (b <= 8'h5A);
    is_lo  = (b >= 8'h61) && (b <= 8'h7A);
    folded = is_lo ? (b - 8'h20) : b;
    r      = b;
    unique case (op)
      OpUpper: if (is_lo) r = b - 8'h20;
      OpLower: if (is_up) r = b + 8'h20;
      OpLeet: begin
        // Case-fold once so each letter is matched in a single pass, no chaining.
        if (is_up || is_lo) begin
          case (folded)
            8'h45:   r = 8'h33;
            8'h53:   r = 8'h35;
            8'h4C:   r = 8'h31;
            8'h41:   r = 8'h34;
            8'h4F:   r = 8'h30;
            default: r = b;
          endcase
        end
      end
      OpRot13: begin
        if (is_up) r = (b <= 8'h4D) ? (b + 8'd13) : (b - 8'd13);
        if (is_lo) r = (b <= 8'h6D) ? (b + 8'd13) : (b - 8'd13);
      end
      default: r = b;
    endcase
    return r;
  endfunction

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] work_q, work_d;
  logic [DATA_WIDTH-1:0] work_step;
  op_e                   op_q, op_d;
  logic                  last_step;

  // Transform only the lanes owned by the current step; others pass through.
  always_comb begin
    work_step = work_q;
    for (int unsigned i = 0; i < NumLanes; i++) begin
      if ((i / LANES_PER_CYCLE) == 32'(cnt_q)) begin
        work_step[8*i +: 8] = xform_byte(op_q, work_q[8*i +: 8]);
      end
    end
  end

  assign last_step = (cnt_q == CntW'(NumSteps - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    work_d   = work_q;
    op_d     = op_q;
    if (str_if.flush_i) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (str_if.enable_i) begin
            work_d  = str_if.operand_i;
            op_d    = op_e'(str_if.operator_i);
            cnt_d   = '0;
            state_d = StBusy;
          end
        end
        StBusy: begin
          work_d = work_step;
          if (last_step) begin
            result_d = work_step;
            cnt_d    = '0;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StDone: begin
          if (str_if.ex_ready_i) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath scratch state; nothing observable depends on it before a request.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    op_q   <= op_d;
  end

  assign str_if.result_o = result_q;
  assign str_if.valid_o  = (state_q == StDone);
  assign str_if.ready_o  = (state_q == StIdle);

endmodule

// File: tb/tb_riscv_str_unit.sv
// Randomized self-checking bench for riscv_str_unit against a byte-level ASCII model.
// Covers 32b/1 lane (main), 32b/4 lanes and 64b/2 lanes configurations.
module tb_riscv_str_unit;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] last_a;
  logic [7:0]  edge_bytes [4] = '{8'h40, 8'h5B, 8'h60, 8'h7B};

  always #5 clk = ~clk;

  riscv_str_unit_if #(.DATA_WIDTH(32)) a_if ();
  riscv_str_unit_if #(.DATA_WIDTH(32)) b_if ();
  riscv_str_unit_if #(.DATA_WIDTH(64)) c_if ();

  riscv_str_unit #(.DATA_WIDTH(32), .LANES_PER_CYCLE(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .str_if(a_if.slave)
  );
  riscv_str_unit #(.DATA_WIDTH(32), .LANES_PER_CYCLE(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .str_if(b_if.slave)
  );
  riscv_str_unit #(.DATA_WIDTH(64), .LANES_PER_CYCLE(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .str_if(c_if.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: ASCII rules expressed with plain integer arithmetic.
  function automatic logic [7:0] ref_byte(int op, logic [7:0] b);
    int c;
    int u;
    bit lo;
    bit up;
    c  = int'(b);
    lo = (c >= 97) && (c <= 122);
    up = (c >= 65) && (c <= 90);
    case (op)
      0: if (lo) return 8'(c - 32);
      1: if (up) return 8'(c + 32);
      2: if (lo || up) begin
        u = lo ? c - 32 : c;
        if (u == 69) return 8'd51;
        if (u == 83) return 8'd53;
        if (u == 76) return 8'd49;
        if (u == 65) return 8'd52;
        if (u == 79) return 8'd48;
      end
      default: begin
        if (lo) return 8'(97 + (c - 97 + 13) % 26);
        if (up) return 8'(65 + (c - 65 + 13) % 26);
      end
    endcase
    return b;
  endfunction

  function automatic logic [63:0] ref_word(int op, logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = ref_byte(op, w[8*i +: 8]);
    return r;
  endfunction

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 4))
      0:       return 8'(97 + $urandom_range(0, 25));
      1:       return 8'(65 + $urandom_range(0, 25));
      2:       return edge_bytes[$urandom_range(0, 3)];
      3:       return 8'(128 + $urandom_range(0, 127));
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = rand_byte();
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full request on the 32b/1-lane unit, optionally with ignored enable noise.
  task automatic run_a(input int op, input logic [31:0] opnd, input string tag,
                       input int hold, input bit noise);
    logic [63:0] full;
    logic [31:0] exp;
    int          cyc;
    bit          ready_low;
    bit          stable;
    full = ref_word(op, {32'h0, opnd});
    exp  = full[31:0];
    cyc  = 0;
    while (!a_if.ready_o && cyc < 20) begin
      step();
      cyc++;
    end
    check($sformatf("%s idle", tag), a_if.ready_o, 1'b1);
    a_if.enable_i   = 1'b1;
    a_if.operator_i = 2'(op);
    a_if.operand_i  = opnd;
    step();
    a_if.enable_i = 1'b0;
    cyc       = 0;
    ready_low = 1'b1;
    while (!a_if.valid_o && cyc < 20) begin
      if (a_if.ready_o) ready_low = 1'b0;
      if (noise) begin
        a_if.enable_i   = 1'($urandom_range(0, 1));
        a_if.operator_i = 2'($urandom);
        a_if.operand_i  = $urandom;
      end
      step();
      cyc++;
    end
    check($sformatf("%s latency", tag), 64'(cyc), 64'd4);
    check($sformatf("%s ready_low", tag), ready_low, 1'b1);
    check($sformatf("%s result op=%0d in=%h", tag, op, opnd), a_if.result_o, exp);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      if (noise) a_if.enable_i = 1'($urandom_range(0, 1));
      step();
      if (a_if.valid_o !== 1'b1 || a_if.result_o !== exp || a_if.ready_o !== 1'b0) stable = 1'b0;
    end
    check($sformatf("%s hold", tag), stable, 1'b1);
    a_if.ex_ready_i = 1'b1;
    a_if.enable_i   = noise;
    step();
    a_if.ex_ready_i = 1'b0;
    a_if.enable_i   = 1'b0;
    check($sformatf("%s release", tag), {a_if.valid_o, a_if.ready_o}, 2'b01);
    last_a = exp;
  endtask

  initial begin
    int          cyc;
    bit          ok;
    logic [63:0] w;
    logic [63:0] e;
    int          op;

    rst_n = 1'b0;
    a_if.enable_i = 0; a_if.operator_i = 0; a_if.operand_i = 0;
    a_if.flush_i  = 0; a_if.ex_ready_i = 0;
    b_if.enable_i = 0; b_if.operator_i = 0; b_if.operand_i = 0;
    b_if.flush_i  = 0; b_if.ex_ready_i = 0;
    c_if.enable_i = 0; c_if.operator_i = 0; c_if.operand_i = 0;
    c_if.flush_i  = 0; c_if.ex_ready_i = 0;
    step();
    step();
    check("reset a", {a_if.result_o, a_if.valid_o, a_if.ready_o}, {32'h0, 2'b01});
    check("reset b", {b_if.result_o, b_if.valid_o, b_if.ready_o}, {32'h0, 2'b01});
    check("reset c", {c_if.result_o, c_if.valid_o, c_if.ready_o}, {64'h0, 2'b01});
    rst_n = 1'b1;
    step();

    run_a(0, 32'h6C6C6548, "upper_hell", 5, 1'b1);
    check("upper_hell const", last_a, 32'h4C4C4548);
    run_a(2, 32'h6C6C6548, "leet_hell", 2, 1'b0);
    check("leet_hell const", last_a, 32'h31313348);
    run_a(3, 32'h7A6E6141, "rot13_anz", 1, 1'b1);
    check("rot13_anz const", last_a, 32'h6D616E4E);
    run_a(1, 32'h5B5A4140, "lower_edge", 0, 1'b0);
    check("lower_edge const", last_a, 32'h5B7A6140);
    run_a(0, 32'hFF7B6040, "upper_bound", 0, 1'b0);

    repeat (40) begin
      w = rand_word();
      run_a(int'($urandom_range(0, 3)), w[31:0], "rand",
            int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    // Flush mid-BUSY: no result, previous result kept.
    a_if.enable_i   = 1'b1;
    a_if.operator_i = 2'd0;
    a_if.operand_i  = 32'h61626364;
    step();
    a_if.enable_i = 1'b0;
    step();
    step();
    a_if.flush_i = 1'b1;
    step();
    a_if.flush_i = 1'b0;
    check("flush idle", {a_if.valid_o, a_if.ready_o}, 2'b01);
    check("flush result kept", a_if.result_o, last_a);
    ok = 1'b1;
    repeat (6) begin
      step();
      if (a_if.valid_o !== 1'b0 || a_if.ready_o !== 1'b1) ok = 1'b0;
    end
    check("flush no valid", ok, 1'b1);

    // Flush wins over enable in IDLE.
    a_if.enable_i = 1'b1;
    a_if.flush_i  = 1'b1;
    step();
    a_if.enable_i = 1'b0;
    a_if.flush_i  = 1'b0;
    check("flush+enable stays idle", {a_if.valid_o, a_if.ready_o}, 2'b01);
    step();
    check("flush+enable later", {a_if.valid_o, a_if.ready_o}, 2'b01);

    // Asynchronous reset mid-BUSY.
    a_if.enable_i   = 1'b1;
    a_if.operator_i = 2'd3;
    a_if.operand_i  = 32'h41424344;
    step();
    a_if.enable_i = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("reset mid busy", {a_if.result_o, a_if.valid_o, a_if.ready_o}, {32'h0, 2'b01});
    step();
    rst_n = 1'b1;
    step();
    w = rand_word();
    run_a(0, w[31:0], "post_reset", 1, 1'b0);

    // 32b, 4 lanes per cycle: single BUSY cycle.
    repeat (12) begin
      w  = rand_word();
      op = int'($urandom_range(0, 3));
      e  = ref_word(op, {32'h0, w[31:0]});
      b_if.enable_i   = 1'b1;
      b_if.operator_i = 2'(op);
      b_if.operand_i  = w[31:0];
      step();
      b_if.enable_i = 1'b0;
      cyc = 0;
      while (!b_if.valid_o && cyc < 20) begin
        step();
        cyc++;
      end
      check("lanes4 latency", 64'(cyc), 64'd1);
      check($sformatf("lanes4 result op=%0d in=%h", op, w[31:0]), b_if.result_o, e[31:0]);
      b_if.ex_ready_i = 1'b1;
      step();
      b_if.ex_ready_i = 1'b0;
    end

    // 64b, 2 lanes per cycle: four BUSY cycles.
    repeat (12) begin
      w  = rand_word();
      op = int'($urandom_range(0, 3));
      e  = ref_word(op, w);
      c_if.enable_i   = 1'b1;
      c_if.operator_i = 2'(op);
      c_if.operand_i  = w;
      step();
      c_if.enable_i = 1'b0;
      cyc = 0;
      while (!c_if.valid_o && cyc < 20) begin
        step();
        cyc++;
      end
      check("w64 latency", 64'(cyc), 64'd4);
      check($sformatf("w64 result op=%0d in=%h", op, w), c_if.result_o, e);
      c_if.ex_ready_i = 1'b1;
      step();
      c_if.ex_ready_i = 1'b0;
      check("w64 release", {c_if.valid_o, c_if.ready_o}, 2'b01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
